// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with call/return stack and run/halt/fault control
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 8,
  parameter int INCR        = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [2:0]                           op,
  input  logic                                 cond,
  input  logic [ADDR_WIDTH-1:0]                target,
  input  logic                                 resume,
  output logic [ADDR_WIDTH-1:0]                pc,
  output logic                                 halted,
  output logic                                 fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   stack [0:(1<<IW)-1];
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   stack_top;
  logic                    stack_full;
  logic                    stack_empty;
  logic                    push;

  assign pc_inc      = pc + ADDR_WIDTH'(INCR);
  assign stack_full  = (depth == DW'(STACK_DEPTH));
  assign stack_empty = (depth == '0);
  assign stack_top   = stack[IW'(depth - DW'(1))];
  assign push        = (state == RUN) && en && (op == OP_CALL) && !stack_full;

  // Entries carry no reset; depth alone decides which ones are live.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[IW'(depth)] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      pc     <= ADDR_WIDTH'(RESET_ADDR);
      depth  <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            case (op)
              OP_JUMP:   pc <= target;
              OP_BRANCH: pc <= cond ? target : pc_inc;
              OP_CALL: begin
                if (stack_full) begin
                  fault  <= 1'b1;
                  halted <= 1'b1;
                  state  <= FAULT;
                end else begin
                  pc    <= target;
                  depth <= depth + DW'(1);
                end
              end
              OP_RET: begin
                if (stack_empty) begin
                  fault  <= 1'b1;
                  halted <= 1'b1;
                  state  <= FAULT;
                end else begin
                  pc    <= stack_top;
                  depth <= depth - DW'(1);
                end
              end
              OP_HALT: begin
                halted <= 1'b1;
                state  <= HALTED;
              end
              default:   pc <= pc_inc;
            endcase
          end
        end
        HALTED: begin
          if (resume) begin
            halted <= 1'b0;
            pc     <= pc_inc;
            state  <= RUN;
          end
        end
        // FAULT is terminal until reset.
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int AW = 16;
  localparam int SD = 8;
  localparam int INC = 4;
  localparam int RA = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          cond = 1'b0;
  logic [AW-1:0] target = '0;
  logic          resume = 1'b0;
  logic [AW-1:0] pc;
  logic          halted;
  logic          fault;
  logic [3:0]    depth;

  pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .INCR(INC), .RESET_ADDR(RA)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .target(target),
    .resume(resume), .pc(pc), .halted(halted), .fault(fault), .depth(depth)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 run, 1 halted, 2 fault; return stack as a queue.
  int            m_mode;
  logic [AW-1:0] m_pc;
  logic          m_fault;
  logic [AW-1:0] m_stk [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_mode != 0));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("depth", 32'(depth), 32'(m_stk.size()));
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc = AW'(RA);
    m_fault = 1'b0;
    m_stk.delete();
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic c,
                      input logic [AW-1:0] t, input logic r);
    en = e; op = o; cond = c; target = t; resume = r;
    @(posedge clk);
    if (m_mode == 0 && e) begin
      case (o)
        3'd1: m_pc = t;
        3'd2: m_pc = c ? t : m_pc + AW'(INC);
        3'd3: begin
          if (m_stk.size() == SD) begin m_mode = 2; m_fault = 1'b1; end
          else begin m_stk.push_back(m_pc + AW'(INC)); m_pc = t; end
        end
        3'd4: begin
          if (m_stk.size() == 0) begin m_mode = 2; m_fault = 1'b1; end
          else m_pc = m_stk.pop_back();
        end
        3'd5: m_mode = 1;
        default: m_pc = m_pc + AW'(INC);
      endcase
    end else if (m_mode == 1 && r) begin
      m_mode = 0;
      m_pc = m_pc + AW'(INC);
    end
    #1;
    chk_model();
  endtask

  // Asserts reset between edges and checks it acts without a clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #7;
    chk_model();
    chk("reset_pc", 32'(pc), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Sequential stepping
    step(1, 3'd0, 0, '0, 0);
    chk("next1", 32'(pc), 32'h4);
    step(1, 3'd0, 0, '0, 0);
    chk("next2", 32'(pc), 32'h8);
    step(1, 3'd6, 0, '0, 0);
    chk("next3_op6", 32'(pc), 32'hC);
    step(0, 3'd1, 0, 16'h1234, 0);
    chk("en0_hold", 32'(pc), 32'hC);

    // Branch
    step(1, 3'd1, 0, 16'h0010, 0);
    step(1, 3'd2, 0, 16'h0100, 0);
    chk("branch_nt", 32'(pc), 32'h0014);
    step(1, 3'd2, 1, 16'h0100, 0);
    chk("branch_t", 32'(pc), 32'h0100);

    // Call / return
    step(1, 3'd1, 0, 16'h0020, 0);
    step(1, 3'd3, 0, 16'h0200, 0);
    chk("call_pc", 32'(pc), 32'h0200);
    chk("call_depth", 32'(depth), 32'd1);
    step(1, 3'd4, 0, '0, 0);
    chk("ret_pc", 32'(pc), 32'h0024);
    chk("ret_depth", 32'(depth), 32'd0);

    // Stack overflow
    for (int i = 1; i <= SD; i++) step(1, 3'd3, 0, AW'(i * 16'h100), 0);
    chk("full_depth", 32'(depth), 32'(SD));
    step(1, 3'd3, 0, 16'hBEEF, 0);
    chk("ovf_pc", 32'(pc), 32'h0800);
    chk("ovf_fault", 32'(fault), 32'd1);
    chk("ovf_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 3'(i + 1), 1, 16'h4444, 1);
    chk("fault_frozen", 32'(pc), 32'h0800);
    async_reset();
    chk("fault_rst_fault", 32'(fault), 32'd0);
    chk("fault_rst_pc", 32'(pc), 32'(RA));

    // Underflow
    step(1, 3'd4, 0, '0, 0);
    chk("udf_fault", 32'(fault), 32'd1);
    async_reset();

    // Halt / resume
    step(1, 3'd1, 0, 16'h0030, 0);
    step(1, 3'd5, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 3'd1, 1, 16'h0777, 0);
    chk("halt_pc", 32'(pc), 32'h0030);
    chk("halt_flag", 32'(halted), 32'd1);
    step(0, 3'd0, 0, '0, 1);
    chk("resume_pc", 32'(pc), 32'h0034);
    chk("resume_halted", 32'(halted), 32'd0);
    step(0, 3'd0, 0, '0, 1);
    chk("resume_in_run", 32'(pc), 32'h0034);

    // Wrap and asynchronous reset
    step(1, 3'd1, 0, 16'hFFFC, 0);
    step(1, 3'd0, 0, '0, 0);
    chk("wrap", 32'(pc), 32'h0000);
    step(1, 3'd1, 0, 16'h5A5A, 0);
    async_reset();
    chk("async_rst_pc", 32'(pc), 32'(RA));

    // Randomized operation mix, occasional mid-cycle resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      else step(1'($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                1'($urandom), AW'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
